// File: rtl/seq_definitions.sv
// Shared widths, op encodings and assembler state encodings for the sequencer.
package seq_definitions;

    localparam int seq_dp_width = 8;
    localparam int seq_in_width = 16;

    // Opcode lives in the top nibble of the high byte.
    typedef enum logic [3:0] {
        SEQ_OP_NOP   = 4'h0,
        SEQ_OP_WAIT  = 4'h1,
        SEQ_OP_SET   = 4'h2,
        SEQ_OP_CLR   = 4'h3,
        SEQ_OP_LOAD  = 4'h4,
        SEQ_OP_JUMP  = 4'h5,
        SEQ_OP_LOOP  = 4'h6,
        SEQ_OP_HALT  = 4'hF
    } seq_op_e;

    typedef enum logic {
        ASM_IDLE = 1'b0,
        ASM_HIGH = 1'b1
    } seq_asm_state_e;

    function automatic seq_op_e seq_get_op(input logic [seq_in_width-1:0] inst);
        return seq_op_e'(inst[seq_in_width-1 -: 4]);
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Instruction buffer: power-of-two circular FIFO with combinational head read.
// A push while full is accepted only if a pop happens in the same cycle.
module seq_fifo
    import seq_definitions::*;
#(
    parameter int WIDTH = seq_in_width,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign count_o = count_q;
    // Empty FIFO presents zero so the output is defined regardless of stale storage.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // Storage write; no reset needed because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/seq_rx_asm.sv
// Assembles UART bytes (high first, then low) into 16-bit instructions and
// buffers them. A held high byte is dropped after TIMEOUT_CYC idle cycles.
//   state    | meaning
//   ASM_IDLE | no byte held; next byte is a high byte
//   ASM_HIGH | high byte held; next byte completes the instruction
module seq_rx_asm
    import seq_definitions::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [seq_dp_width-1:0]        i_rx_data,
    input  logic                           i_rx_valid,
    output logic [seq_in_width-1:0]        o_inst,
    output logic                           o_inst_valid,
    input  logic                           i_inst_ready,
    input  logic                           i_clr_ovf,
    output logic                           o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count
);

    // Expiry happens on the TIMEOUT_CYC-th idle cycle; a byte on that cycle still counts.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    seq_asm_state_e          state_q;
    logic [seq_dp_width-1:0] high_q;
    logic [15:0]             tmo_q;
    logic                    overflow_q;

    logic                    push_w;
    logic                    pop_w;
    logic                    full_w;
    logic                    empty_w;
    logic [seq_in_width-1:0] inst_w;

    // The low byte is pushed in the cycle it arrives so the FIFO sees it one cycle later.
    assign push_w = (state_q == ASM_HIGH) & i_rx_valid;
    assign inst_w = {high_q, i_rx_data};
    assign pop_w  = ~empty_w & i_inst_ready;

    // Byte assembler FSM with idle timeout on the held high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ASM_IDLE;
            high_q  <= '0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                ASM_IDLE: begin
                    if (i_rx_valid) begin
                        high_q  <= i_rx_data;
                        tmo_q   <= '0;
                        state_q <= ASM_HIGH;
                    end
                end
                ASM_HIGH: begin
                    if (i_rx_valid) begin
                        high_q  <= '0;
                        state_q <= ASM_IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        high_q  <= '0;
                        tmo_q   <= '0;
                        state_q <= ASM_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ASM_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped push wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (push_w & full_w & ~pop_w) begin
            overflow_q <= 1'b1;
        end else if (i_clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    seq_fifo #(
        .WIDTH (seq_in_width),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_w),
        .data_i  (inst_w),
        .pop_i   (pop_w),
        .data_o  (o_inst),
        .full_o  (full_w),
        .empty_o (empty_w),
        .count_o (o_fifo_count)
    );

    assign o_inst_valid = ~empty_w;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_seq_rx_asm.sv
// Randomised and directed bench for the byte-to-instruction assembler.
module tb_seq_rx_asm;

    localparam int TO    = 20;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic [15:0] o_inst;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;
    logic        i_clr_ovf = 1'b0;
    logic        o_overflow;
    logic [2:0]  o_fifo_count;

    seq_rx_asm #(.TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_inst       (o_inst),
        .o_inst_valid (o_inst_valid),
        .i_inst_ready (i_inst_ready),
        .i_clr_ovf    (i_clr_ovf),
        .o_overflow   (o_overflow),
        .o_fifo_count (o_fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: timestamps for the held byte, an occupancy count,
    // and the scoreboard of instructions the consumer should see, in order.
    logic [15:0] exp_q[$];
    int          m_cnt   = 0;
    bit          m_ovf   = 0;
    bit          m_held  = 0;
    logic [7:0]  m_hb    = '0;
    int          m_thigh = 0;
    int          cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every handshake must deliver the oldest expected instruction.
    always @(negedge clk) begin
        if (!rst && o_inst_valid === 1'b1 && i_inst_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected at cycle %0d: got 0x%0h expected no instruction", cyc, o_inst);
            end else begin
                chk("pop_data", 32'(o_inst), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock cycle: check state left by the previous edge, drive inputs, advance model.
    task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit clr, input bit r);
        bit          pop;
        bit          formed;
        bit          evt;
        logic [15:0] inst;
        chk("count",    32'(o_fifo_count), 32'(m_cnt));
        chk("overflow", 32'(o_overflow),   32'(m_ovf));
        chk("valid",    32'(o_inst_valid), 32'(m_cnt != 0));
        if (m_cnt == 0) chk("inst_empty", 32'(o_inst), 32'h0);

        i_rx_valid   = v;
        i_rx_data    = d;
        i_inst_ready = rdy;
        i_clr_ovf    = clr;
        rst          = r;

        if (r) begin
            m_held = 0;
            m_cnt  = 0;
            m_ovf  = 0;
            exp_q.delete();
        end else begin
            pop    = (m_cnt > 0) && rdy;
            formed = 0;
            evt    = 0;
            inst   = '0;
            if (v) begin
                if (m_held && (cyc - m_thigh) <= TO) begin
                    formed = 1;
                    inst   = {m_hb, d};
                    m_held = 0;
                end else begin
                    m_held  = 1;
                    m_hb    = d;
                    m_thigh = cyc;
                end
            end
            if (formed) begin
                if (m_cnt < DEPTH || pop) begin
                    exp_q.push_back(inst);
                    m_cnt++;
                end else begin
                    evt = 1;
                end
            end
            if (pop) m_cnt--;
            if (evt)      m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'h00, rdy, 0, 0);
    endtask

    task automatic send(input logic [15:0] inst, input bit rdy);
        step(1, inst[15:8], rdy, 0, 0);
        step(1, inst[7:0],  rdy, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);

        // Basic assembly with consumer ready.
        send(16'h4123, 1);
        idle(3, 1);

        // Timeout discards the held byte.
        step(1, 8'h41, 1, 0, 0);
        idle(TO, 1);
        send(16'h1234, 1);
        idle(3, 1);

        // Low byte on the expiry cycle still forms an instruction.
        step(1, 8'h77, 1, 0, 0);
        idle(TO - 1, 1);
        step(1, 8'h88, 1, 0, 0);
        idle(3, 1);

        // Overflow with consumer stalled, then drain and clear.
        for (int i = 1; i <= 5; i++) send(16'(i), 0);
        idle(2, 0);
        idle(6, 1);
        step(0, 8'h00, 1, 1, 0);
        idle(2, 1);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) send(16'h0011 + 16'(i), 0);
        step(1, 8'h00, 0, 0, 0);
        step(1, 8'hAA, 1, 0, 0);
        idle(2, 0);
        idle(6, 1);

        // Clear and overflow in the same cycle: set wins.
        for (int i = 0; i < 4; i++) send(16'h0B00 + 16'(i), 0);
        step(1, 8'hCC, 0, 0, 0);
        step(1, 8'hDD, 0, 1, 0);
        idle(2, 0);
        step(0, 8'h00, 0, 1, 0);
        idle(6, 1);

        // Reset between high and low byte; byte during reset is ignored.
        step(1, 8'h41, 1, 0, 0);
        step(1, 8'h23, 1, 0, 1);
        send(16'h5566, 1);
        idle(3, 1);

        // Randomised traffic with gaps long enough to hit the timeout.
        for (int blk = 0; blk < 60; blk++) begin
            int gap;
            int burst;
            gap   = $urandom_range(0, 2 * TO);
            burst = $urandom_range(1, 7);
            for (int i = 0; i < gap; i++)
                step(0, 8'h00, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), 0);
            for (int i = 0; i < burst; i++)
                step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 15) == 0), ($urandom_range(0, 60) == 0));
        end

        idle(DEPTH + 4, 1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_rx_asm.md
SEQ_RX_ASM -- requirements
Module: seq_rx_asm

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: idle cycles after a high byte before that partial instruction is discarded; range 1..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: instruction buffer entries; power of two, minimum 2.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port i_rx_data, input, seq_dp_width (8): received UART byte.
REQ-006 Port i_rx_valid, input, 1: one-cycle strobe; i_rx_data is valid this cycle.
REQ-007 Port o_inst, output, seq_in_width (16): instruction at the FIFO head.
REQ-008 Port o_inst_valid, output, 1: FIFO not empty; o_inst is valid.
REQ-009 Port i_inst_ready, input, 1: consumer accepts o_inst this cycle.
REQ-010 Port i_clr_ovf, input, 1: clears o_overflow.
REQ-011 Port o_overflow, output, 1: sticky flag; an instruction was dropped because the FIFO was full.
REQ-012 Port o_fifo_count, output, log2(FIFO_DEPTH)+1: number of buffered instructions.

Function
REQ-013 Instructions arrive high byte first (bits 15:8, containing op), then low byte (bits 7:0).
REQ-014 The assembler has two states: IDLE (no byte held) and HIGH (high byte held).
- IDLE + i_rx_valid: latch the byte as the high byte; go to HIGH; clear the timeout counter.
- HIGH + i_rx_valid: form {high, i_rx_data}; push it to the FIFO; go to IDLE.
REQ-015 In HIGH, the timeout counter increments on each cycle without i_rx_valid.
- When it reaches TIMEOUT_CYC, the held byte is discarded and the state returns to IDLE.
- If i_rx_valid occurs on the expiry cycle, the byte is taken as the low byte.
REQ-016 Push latency: a low byte accepted in cycle N gives o_inst_valid=1 in cycle N+1 when the FIFO was empty.
REQ-017 Pop occurs when o_inst_valid & i_inst_ready; o_inst is a combinational read of the head entry, so there is no read latency.
REQ-018 FIFO full on push without pop: the instruction is dropped, FIFO contents are unchanged, and o_overflow is set.
REQ-019 FIFO full with simultaneous push and pop: both are performed, the count is unchanged, and no overflow is flagged.
REQ-020 FIFO empty: o_inst_valid=0, and i_inst_ready is ignored.
REQ-021 Read and write pointers wrap modulo FIFO_DEPTH; o_fifo_count saturates at FIFO_DEPTH.
REQ-022 When i_clr_ovf and an overflow event occur in the same cycle, o_overflow stays 1 (set wins).
REQ-023 The assembler never stalls i_rx_valid; every byte is consumed in the cycle it arrives.

Reset
REQ-024 On rst=1 the block goes to IDLE and clears the held byte, timeout counter, FIFO pointers and count, and o_overflow.
REQ-025 Output values during and after reset: o_inst_valid=0, o_fifo_count=0, o_overflow=0, o_inst=0.
REQ-026 Reset mid-instruction (in HIGH) discards the held byte; the next byte after reset is treated as a high byte.
REQ-027 Inputs in the cycle that rst is asserted are ignored.

Structure
REQ-028 seq_dp_width, seq_in_width and the op encodings come from the shared seq_definitions package; the two state encodings are also defined there.
REQ-029 The FIFO is a separate sub-module, seq_fifo, parameterised by width and depth, with push/pop/full/empty/count ports.
REQ-030 The assembler FSM and timeout counter are in seq_rx_asm; there is no other sub-module.

Verification
REQ-031 Bytes 0x41 then 0x23 with ready=1 -> o_inst=0x4123 with valid for exactly one cycle, one cycle after 0x23.
REQ-032 Byte 0x41, then TIMEOUT_CYC idle cycles, then 0x12, 0x34 -> single instruction 0x1234; 0x41 is discarded.
REQ-033 ready=0, push 5 instructions 0x0001..0x0005 with depth 4 -> count=4, overflow=1, pops return 0x0001..0x0004.
REQ-034 FIFO full, then simultaneous pop and push of 0x00AA -> count stays 4, overflow=0, 0x00AA is last out.
REQ-035 rst asserted between 0x41 and 0x23, then bytes 0x55, 0x66 -> only 0x5566 is emitted.
REQ-036 Low byte arrives exactly on the timeout-expiry cycle -> instruction is formed, not discarded.
